// File: rtl/hex_word_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : hex_word_loader_if
// Description : Bus bundle for the hex word loader. Carries the UART receive
//               handshake, the echo transmit handshake and the instruction
//               memory write port. The master side is the loader itself; the
//               slave side is the UART / memory environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface hex_word_loader_if #(
  parameter int AW = 4
);

  // UART receive side
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ack;

  // UART transmit (echo) side
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;

  // Instruction memory write port
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    output rx_ack, tx_data, tx_start, wr_en, wr_addr, wr_data
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    input  rx_ack, tx_data, tx_start, wr_en, wr_addr, wr_data
  );

endinterface

`default_nettype wire

// File: rtl/hex_word_loader.sv
`default_nettype none
// ============================================================================
// Module      : hex_word_loader
// Description : Assembles 32-bit instruction words from ASCII hex digits
//               received over a UART and writes them to consecutive
//               instruction-memory addresses. Every accepted byte is echoed.
//               Space and end-of-line bytes are separators, '!' clears the
//               loader, anything else is a format error (sticky err).
// Options     : LOWERCASE_HEX_EN - when defined, 'a'..'f' are hex digits;
//               otherwise they are treated as invalid bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_word_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  hex_word_loader_if.master  bus,
  input  wire logic          load_en,
  output logic [AW:0]        word_count,
  output logic               full,
  output logic               err
);

  // Word count at which the memory is considered full.
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Byte codes with special meaning.
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_CLEAR = 8'h21;

  // IDLE waits for a byte; WAIT holds off until the UART drops rx_valid so a
  // single byte is never consumed twice.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;

  logic [31:0]   shift_q, shift_d;
  logic [2:0]    nib_cnt_q, nib_cnt_d;
  logic [AW:0]   word_count_q, word_count_d;
  logic          err_q, err_d;

  logic          rx_ack_q, rx_ack_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;

  logic [7:0]    rx_byte;
  logic          accept;
  logic          is_hex;
  logic [3:0]    nibble;
  logic [31:0]   shifted;
  logic          word_done;
  logic          is_full;

  assign rx_byte   = bus.rx_data;
  assign is_full   = (word_count_q == FULL_COUNT);
  assign shifted   = {shift_q[27:0], nibble};
  assign word_done = (nib_cnt_q == 3'd7);

  // A byte is taken only from IDLE, with the transmitter free to echo it
  // and loading enabled.
  assign accept = (state_q == IDLE) && bus.rx_valid && !bus.tx_busy && load_en;

  // Translate the received byte into a hex nibble, flagging non-digits.
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (rx_byte inside {[8'h30:8'h39]}) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0];
    end else if (rx_byte inside {[8'h41:8'h46]}) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0] + 4'd9;
    end
`ifdef LOWERCASE_HEX_EN
    else if (rx_byte inside {[8'h61:8'h66]}) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0] + 4'd9;
    end
`else
    // Lower-case letters fall through as invalid bytes in this build.
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one byte per rx_valid assertion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!bus.rx_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output pulses computed from the accepted byte.
  always_comb begin
    shift_d      = shift_q;
    nib_cnt_d    = nib_cnt_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    rx_ack_d     = 1'b0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    if (accept) begin
      // Every accepted byte is acknowledged and echoed, valid or not.
      rx_ack_d   = 1'b1;
      tx_start_d = 1'b1;
      tx_data_d  = rx_byte;

      if (is_hex) begin
        shift_d = shifted;
        if (word_done) begin
          nib_cnt_d = 3'd0;
          if (is_full) begin
            // No room left: the completed word is dropped.
            err_d = 1'b1;
          end else begin
            wr_en_d      = 1'b1;
            wr_addr_d    = word_count_q[AW-1:0];
            wr_data_d    = shifted;
            word_count_d = word_count_q + {{AW{1'b0}}, 1'b1};
          end
        end else begin
          nib_cnt_d = nib_cnt_q + 3'd1;
        end
      end else begin
        case (rx_byte)
          CHAR_SPACE: begin
            // Separator only.
          end
          CHAR_CR, CHAR_LF: begin
            // End of line in the middle of a word truncates it.
            if (nib_cnt_q != 3'd0) begin
              nib_cnt_d = 3'd0;
              shift_d   = 32'h0;
              err_d     = 1'b1;
            end
          end
          CHAR_CLEAR: begin
            word_count_d = '0;
            nib_cnt_d    = 3'd0;
            shift_d      = 32'h0;
            err_d        = 1'b0;
          end
          default: begin
            nib_cnt_d = 3'd0;
            shift_d   = 32'h0;
            err_d     = 1'b1;
          end
        endcase
      end
    end
  end

  // Datapath and output registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= 32'h0;
      nib_cnt_q    <= 3'd0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      rx_ack_q     <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'h0;
    end else begin
      shift_q      <= shift_d;
      nib_cnt_q    <= nib_cnt_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      rx_ack_q     <= rx_ack_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.rx_ack   = rx_ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

  assign word_count = word_count_q;
  assign full       = is_full;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_word_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_word_loader
// Description : Directed, table-driven bench for hex_word_loader (DEPTH=16)
//               with hand-written sequences for busy/stall/fill/reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_word_loader;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [AW:0] word_count;
  logic        full;
  logic        err;

  hex_word_loader_if #(.AW(AW)) bus ();

  hex_word_loader #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .load_en   (load_en),
    .word_count(word_count),
    .full      (full),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Pulse counters sampled away from the active edge.
  int ack_cnt = 0;
  int txs_cnt = 0;
  int wr_cnt  = 0;

  always @(negedge clk) begin
    if (bus.rx_ack)   ack_cnt = ack_cnt + 1;
    if (bus.tx_start) txs_cnt = txs_cnt + 1;
    if (bus.wr_en)    wr_cnt  = wr_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    if (act === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the acknowledge of byte b, check its echo, then drop
  // rx_valid the way the UART would.
  task automatic wait_ack(input logic [7:0] b);
    int n;
    n = 0;
    while (!bus.rx_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ack) begin
      check("rx_ack_timeout", 32'd0, 32'd1);
    end else begin
      check("echo_tx_start", {31'd0, bus.tx_start}, 32'd1);
      check("echo_tx_data", {24'd0, bus.tx_data}, {24'd0, b});
    end
    bus.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    wait_ack(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
    end
  endtask

  // Send a word as eight upper-case hex digits, MSB first.
  task automatic send_word(input logic [31:0] w);
    logic [3:0] n;
    for (int k = 7; k >= 0; k--) begin
      n = w[k*4 +: 4];
      send_byte((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n}));
    end
  endtask

  typedef struct {
    string       text;
    bit          clear_first;
    int          exp_writes;
    logic [31:0] exp_data;
    logic [3:0]  exp_addr;
    logic [4:0]  exp_count;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input string t, input bit c, input int w, input logic [31:0] d,
                              input logic [3:0] a, input logic [4:0] n, input logic e);
    vec_t v;
    v.text = t; v.clear_first = c; v.exp_writes = w; v.exp_data = d;
    v.exp_addr = a; v.exp_count = n; v.exp_err = e;
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0, a0, t0;

    // Table: text, clear first, writes, wr_data, wr_addr, word_count, err
    vecs[0]  = mk("00500093",      1'b1, 1, 32'h00500093, 4'd0, 5'd1, 1'b0);
    vecs[1]  = mk("DEADBEEF",      1'b0, 1, 32'hDEADBEEF, 4'd1, 5'd2, 1'b0);
    vecs[2]  = mk(" 1234 5678\r",  1'b0, 1, 32'h12345678, 4'd2, 5'd3, 1'b0);
    vecs[3]  = mk("\n\r",          1'b0, 0, 32'h12345678, 4'd2, 5'd3, 1'b0);
    vecs[4]  = mk("12G",           1'b0, 0, 32'h12345678, 4'd2, 5'd3, 1'b1);
    vecs[5]  = mk("DEADBEEF",      1'b0, 1, 32'hDEADBEEF, 4'd3, 5'd4, 1'b1);
    vecs[6]  = mk("12GDEADBEEF",   1'b1, 1, 32'hDEADBEEF, 4'd0, 5'd1, 1'b1);
`ifdef LOWERCASE_HEX_EN
    vecs[7]  = mk("abcd0123",      1'b1, 1, 32'hABCD0123, 4'd0, 5'd1, 1'b0);
`else
    vecs[7]  = mk("abcd0123",      1'b1, 0, 32'hDEADBEEF, 4'd0, 5'd0, 1'b1);
`endif
    vecs[8]  = mk("AB!5678ABCD",   1'b1, 1, 32'h5678ABCD, 4'd0, 5'd1, 1'b0);
    vecs[9]  = mk("12\r",          1'b0, 0, 32'h5678ABCD, 4'd0, 5'd1, 1'b1);
    vecs[10] = mk("1234567\n",     1'b0, 0, 32'h5678ABCD, 4'd0, 5'd1, 1'b1);
    vecs[11] = mk("89ABCDEF",      1'b0, 1, 32'h89ABCDEF, 4'd1, 5'd2, 1'b1);

    rst_n        = 1'b0;
    load_en      = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_busy  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rx_ack",     {31'd0, bus.rx_ack},   32'd0);
    check("rst_tx_start",   {31'd0, bus.tx_start}, 32'd0);
    check("rst_tx_data",    {24'd0, bus.tx_data},  32'd0);
    check("rst_wr_en",      {31'd0, bus.wr_en},    32'd0);
    check("rst_wr_addr",    {28'd0, bus.wr_addr},  32'd0);
    check("rst_wr_data",    bus.wr_data,           32'd0);
    check("rst_word_count", {27'd0, word_count},   32'd0);
    check("rst_full",       {31'd0, full},         32'd0);
    check("rst_err",        {31'd0, err},          32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven vectors
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].clear_first) send_byte(8'h21);
      w0 = wr_cnt;
      send_str(vecs[v].text);
      check($sformatf("v%0d_writes", v), wr_cnt - w0, vecs[v].exp_writes);
      check($sformatf("v%0d_wr_data", v), bus.wr_data, vecs[v].exp_data);
      check($sformatf("v%0d_wr_addr", v), {28'd0, bus.wr_addr}, {28'd0, vecs[v].exp_addr});
      check($sformatf("v%0d_word_count", v), {27'd0, word_count}, {27'd0, vecs[v].exp_count});
      check($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
    end

    // Transmitter busy: byte waits, then is taken exactly once
    send_byte(8'h21);
    a0 = ack_cnt;
    t0 = txs_cnt;
    bus.tx_busy  = 1'b1;
    bus.rx_data  = 8'h35;
    bus.rx_valid = 1'b1;
    repeat (50) @(negedge clk);
    check("busy_no_ack",      ack_cnt - a0, 0);
    check("busy_no_tx_start", txs_cnt - t0, 0);
    bus.tx_busy = 1'b0;
    @(negedge clk);
    wait_ack(8'h35);
    repeat (5) @(negedge clk);
    check("busy_one_ack",      ack_cnt - a0, 1);
    check("busy_one_tx_start", txs_cnt - t0, 1);

    // Loading paused mid-word: partial word survives
    send_byte(8'h21);
    send_str("1234");
    a0 = ack_cnt;
    w0 = wr_cnt;
    load_en      = 1'b0;
    bus.rx_data  = 8'h35;
    bus.rx_valid = 1'b1;
    repeat (20) @(negedge clk);
    check("paused_no_ack", ack_cnt - a0, 0);
    load_en = 1'b1;
    @(negedge clk);
    wait_ack(8'h35);
    send_str("678");
    check("paused_writes",  wr_cnt - w0, 1);
    check("paused_wr_data", bus.wr_data, 32'h12345678);
    check("paused_wr_addr", {28'd0, bus.wr_addr}, 32'd0);

    // Fill the memory, then overflow
    send_byte(8'h21);
    for (int i = 0; i < DEPTH; i++) begin
      send_word(32'hC0DE_0000 + i);
      check($sformatf("fill%0d_addr", i), {28'd0, bus.wr_addr}, i);
      check($sformatf("fill%0d_data", i), bus.wr_data, 32'hC0DE_0000 + i);
      if (i == DEPTH - 2) check("fill_not_full", {31'd0, full}, 32'd0);
    end
    check("fill_full",  {31'd0, full}, 32'd1);
    check("fill_err0",  {31'd0, err},  32'd0);
    w0 = wr_cnt;
    send_str("00000013");
    check("ovf_writes",     wr_cnt - w0, 0);
    check("ovf_word_count", {27'd0, word_count}, 32'd16);
    check("ovf_full",       {31'd0, full}, 32'd1);
    check("ovf_err",        {31'd0, err},  32'd1);
    check("ovf_wr_data",    bus.wr_data,   32'hC0DE_000F);

    // Reset mid-word discards the partial word
    send_str("1234");
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_wr_data",    bus.wr_data, 32'd0);
    check("mid_rst_word_count", {27'd0, word_count}, 32'd0);
    check("mid_rst_err",        {31'd0, err}, 32'd0);
    check("mid_rst_tx_data",    {24'd0, bus.tx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    w0 = wr_cnt;
    send_str("FFFFFFFF");
    check("post_rst_writes",  wr_cnt - w0, 1);
    check("post_rst_wr_data", bus.wr_data, 32'hFFFFFFFF);
    check("post_rst_wr_addr", {28'd0, bus.wr_addr}, 32'd0);
    check("post_rst_count",   {27'd0, word_count}, 32'd1);
    send_byte(8'h5A);
    check("bad_byte_err", {31'd0, err}, 32'd1);
    send_byte(8'h21);
    check("clear_count", {27'd0, word_count}, 32'd0);
    check("clear_err",   {31'd0, err}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hex_word_loader.md
HEX_WORD_LOADER -- requirements
Module: hex_word_loader

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit words in the downstream instruction memory (power of two, 2..256).
REQ-002 Parameter AW, default 4, write address width, equal to log2(DEPTH).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 rx_valid  input  1  byte available; held high until the UART sees rx_ack.
REQ-007 rx_ack  output  1  one-cycle pulse that clears the UART ready flag.
REQ-008 tx_data  output  8  echo byte.
REQ-009 tx_start  output  1  one-cycle pulse that starts transmission of tx_data.
REQ-010 tx_busy  input  1  UART transmitter busy.
REQ-011 load_en  input  1  loading permitted; bytes are not consumed while low.
REQ-012 wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-013 wr_addr  output  AW  word write address.
REQ-014 wr_data  output  32  assembled instruction word.
REQ-015 word_count  output  AW+1  number of words written since reset or clear.
REQ-016 full  output  1  high when word_count equals DEPTH.
REQ-017 err  output  1  sticky error flag: format error or overflow.

Function
REQ-018 The FSM SHALL have exactly two states, IDLE and WAIT.
REQ-019 In IDLE, accept a byte at the edge where rx_valid=1, tx_busy=0 and load_en=1, then enter WAIT.
REQ-020 WAIT SHALL return to IDLE on the first edge at which rx_valid=0; no byte is accepted in WAIT.
REQ-021 At the accepting edge, assert rx_ack and tx_start for exactly one cycle, with tx_data equal to the accepted byte; every accepted byte is echoed, invalid bytes included.
REQ-022 Hex digits 0x30-0x39 map to 0-9 and 0x41-0x46 map to A-F.
REQ-023 On a hex digit: shift = {shift[27:0], nibble} (MSB first), and nib_cnt increments.
REQ-024 On the 8th digit, set nib_cnt to 0 and assert wr_en at the same edge as rx_ack, with wr_addr=word_count[AW-1:0] and wr_data equal to the completed word.
REQ-025 After each write, word_count SHALL increment by 1.
REQ-026 When full=1 and an 8th digit arrives, wr_en SHALL stay 0, word_count SHALL hold, and err SHALL be set; the word is discarded.
REQ-027 0x20 (space) SHALL have no effect on state.
REQ-028 0x0D or 0x0A with nib_cnt=0: no effect.
REQ-029 0x0D or 0x0A with nib_cnt≠0: discard the partial word, set nib_cnt to 0, set err.
REQ-030 0x21 ('!') SHALL clear word_count, nib_cnt, shift and err; no write occurs.
REQ-031 Any other byte SHALL set err, discard any partial word and set nib_cnt to 0.
REQ-032 wr_data and wr_addr SHALL hold their last values between writes.
REQ-033 If load_en falls while nib_cnt≠0, the partial word is retained and completes once loading resumes.
REQ-034 If rx_valid rises in the same cycle that tx_busy falls, the byte is accepted at the next edge where tx_busy=0.

Reset
REQ-035 While rst_n=0, state=IDLE and shift=0, nib_cnt=0, word_count=0.
REQ-036 While rst_n=0, every output SHALL be 0: rx_ack, tx_start, tx_data, wr_en, wr_addr, wr_data, full, err.
REQ-037 Reset asserted mid-word SHALL discard the partial word; after release the block waits in IDLE for a new byte.

Configuration
REQ-038 With LOWERCASE_HEX_EN defined, 0x61-0x66 SHALL be accepted as hex digits A-F.
REQ-039 Without LOWERCASE_HEX_EN, 0x61-0x66 SHALL be treated as invalid bytes (REQ-031).

Verification
REQ-040 Send "00500093" -> one wr_en, wr_addr=0, wr_data=0x00500093, word_count=1, and 8 echoes equal to the sent bytes.
REQ-041 Fill DEPTH=16 words, then send "00000013" -> no wr_en, word_count=16, full=1, err=1.
REQ-042 Send "12G" -> err=1, nib_cnt=0; then send "DEADBEEF" -> wr_data=0xDEADBEEF at wr_addr=0.
REQ-043 Send "abcd0123": with LOWERCASE_HEX_EN defined -> wr_data=0xABCD0123; without it -> err=1 and no write.
REQ-044 Hold tx_busy=1 with rx_valid=1 for 50 cycles -> no rx_ack; release tx_busy -> exactly one rx_ack and one tx_start.
REQ-045 Pulse rst_n low after 4 digits, then send "FFFFFFFF" -> wr_data=0xFFFFFFFF at wr_addr=0; then send "!" -> word_count=0, err=0.
